// File: rtl/seq_control_unit.sv
// seq_control_unit: multi-cycle sequencing FSM for the 8-bit processor.
// Walks FETCH -> DECODE -> EXEC -> (MEM) -> WB and handshakes with memory
// through mem_req/mem_ready. A memory wait that runs too long or an
// undefined opcode traps into a sticky ERR state that only rst clears.
// Control outputs are Moore functions of the state and latched opcode and
// are registered by decoding the next state; ir_we and pc_sel must react
// to mem_ready/eq in the same cycle, so they stay combinational.
module seq_control_unit #(
    parameter int OP_W    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic            eq,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            ir_we,
    output logic            pc_we,
    output logic            pc_sel,
    output logic            J,
    output logic            JC,
    output logic            INA,
    output logic            RM,
    output logic            WM,
    output logic            SIN,
    output logic            SOUT,
    output logic            WR,
    output logic            NEQ,
    output logic            err,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERR    = 3'd7
    } state_t;

    // Table-driven control bundle, bit order: J JC INA RM WM SIN SOUT WR NEQ
    localparam int B_J    = 8;
    localparam int B_JC   = 7;
    localparam int B_INA  = 6;
    localparam int B_RM   = 5;
    localparam int B_WM   = 4;
    localparam int B_SIN  = 3;
    localparam int B_SOUT = 2;
    localparam int B_WR   = 1;
    localparam int B_NEQ  = 0;

    // Which table bits each state is allowed to expose
    localparam logic [8:0] EXEC_MASK = 9'b111001101;
    localparam logic [8:0] MEM_MASK  = 9'b000110000;
    localparam logic [8:0] WB_MASK   = 9'b111001111;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef struct packed {
        logic       memReq;
        logic       pcWe;
        logic       err;
        logic [8:0] ctl;
    } ctrl_t;

    state_t     r_state;
    logic [2:0] r_opQ;
    logic [7:0] r_timer;
    ctrl_t      r_ctrl;

    state_t     w_nextState;
    logic [2:0] w_nextOp;
    logic       w_illegal;
    logic       w_waiting;
    logic       w_timedOut;
    logic       w_isMemOp;

    function automatic logic [8:0] opBits(input logic [2:0] op);
        logic [8:0] b;
        case (op)
            3'd0:    b = 9'b000000100;
            3'd1:    b = 9'b001001000;
            3'd2:    b = 9'b000010000;
            3'd3:    b = 9'b000100010;
            3'd4:    b = 9'b100000000;
            3'd5:    b = 9'b010000000;
            3'd6:    b = 9'b000000010;
            default: b = 9'b010000001;
        endcase
        return b;
    endfunction

    function automatic ctrl_t decodeCtrl(input state_t s, input logic [2:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: c.memReq = 1'b1;
            ST_EXEC:  c.ctl = opBits(op) & EXEC_MASK;
            ST_MEM: begin
                c.memReq = 1'b1;
                c.ctl    = opBits(op) & MEM_MASK;
            end
            ST_WB: begin
                c.ctl  = opBits(op) & WB_MASK;
                c.pcWe = 1'b1;
            end
            ST_ERR:   c.err = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    assign w_illegal  = (32'(opcode) >= 32'd8);
    assign w_waiting  = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready;
    assign w_timedOut = w_waiting && (r_timer == TIMEOUT_LAST);
    assign w_isMemOp  = (r_opQ == 3'd2) || (r_opQ == 3'd3);
    assign w_nextOp   = (r_state == ST_DECODE) ? opcode[2:0] : r_opQ;

    // Next-state selection; mem_ready beats the timeout in the same cycle
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_BOOT:   w_nextState = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)       w_nextState = ST_DECODE;
                else if (w_timedOut) w_nextState = ST_ERR;
                else                 w_nextState = ST_FETCH;
            end
            ST_DECODE: w_nextState = w_illegal ? ST_ERR : ST_EXEC;
            ST_EXEC:   w_nextState = w_isMemOp ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (mem_ready)       w_nextState = ST_WB;
                else if (w_timedOut) w_nextState = ST_ERR;
                else                 w_nextState = ST_MEM;
            end
            ST_WB:     w_nextState = ST_FETCH;
            ST_ERR:    w_nextState = ST_ERR;
            default:   w_nextState = ST_ERR;
        endcase
    end

    // State, latched opcode, wait timer and registered Moore outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
            r_opQ   <= '0;
            r_timer <= '0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_nextState;
            r_opQ   <= w_nextOp;
            r_ctrl  <= decodeCtrl(w_nextState, w_nextOp);
            if (w_nextState != r_state)
                r_timer <= '0;
            else if (w_waiting)
                r_timer <= r_timer + 8'd1;
        end
    end

    assign mem_req = r_ctrl.memReq;
    assign pc_we   = r_ctrl.pcWe;
    assign err     = r_ctrl.err;
    assign J       = r_ctrl.ctl[B_J];
    assign JC      = r_ctrl.ctl[B_JC];
    assign INA     = r_ctrl.ctl[B_INA];
    assign RM      = r_ctrl.ctl[B_RM];
    assign WM      = r_ctrl.ctl[B_WM];
    assign SIN     = r_ctrl.ctl[B_SIN];
    assign SOUT    = r_ctrl.ctl[B_SOUT];
    assign WR      = r_ctrl.ctl[B_WR];
    assign NEQ     = r_ctrl.ctl[B_NEQ];
    assign state   = r_state;

    assign ir_we  = (r_state == ST_FETCH) && mem_ready;
    assign pc_sel = (r_state == ST_WB) &&
                    (r_ctrl.ctl[B_J] || (r_ctrl.ctl[B_JC] && (eq ^ r_ctrl.ctl[B_NEQ])));

endmodule

// File: tb/tb_seq_control_unit.sv
// Testbench for seq_control_unit (OP_W=4, TIMEOUT=4).
// Each instruction is expanded into an expected per-cycle trace from the
// opcode table and the phase rules, then driven and compared cycle by cycle.
module tb_seq_control_unit;

    localparam int TIMEOUT = 4;

    localparam logic [2:0] S_BOOT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                           S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_ERR = 3'd7;

    // ctl order: J JC INA RM WM SIN SOUT WR NEQ
    localparam logic [8:0] EXEC_MASK = 9'b111001101;
    localparam logic [8:0] MEM_MASK  = 9'b000110000;
    localparam logic [8:0] WB_MASK   = 9'b111001111;

    typedef struct packed {
        logic [2:0] st;
        logic       memReq;
        logic       irWe;
        logic       pcWe;
        logic       pcSel;
        logic       err;
        logic [8:0] ctl;
    } outs_t;

    typedef struct {
        logic       memReady;
        logic       eqIn;
        logic [3:0] opIn;
        outs_t      exp;
    } cyc_t;

    typedef struct {
        logic [3:0] op;
        int         fWait;
        int         mWait;
        logic       eqWB;
        int         expPcWeAt;
        logic       expPcSel;
        int         expWr;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic       eq;
    logic       mem_ready;
    logic       mem_req, ir_we, pc_we, pc_sel;
    logic       J, JC, INA, RM, WM, SIN, SOUT, WR, NEQ, err;
    logic [2:0] state;
    outs_t      w_act;

    int         checks = 0;
    int         errors = 0;
    cyc_t       trace[$];
    logic       endsInErr;
    logic [2:0] stateLog[$];

    seq_control_unit #(.OP_W(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .eq(eq), .mem_ready(mem_ready),
        .mem_req(mem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .J(J), .JC(JC), .INA(INA), .RM(RM), .WM(WM), .SIN(SIN), .SOUT(SOUT),
        .WR(WR), .NEQ(NEQ), .err(err), .state(state)
    );

    assign w_act = {state, mem_req, ir_we, pc_we, pc_sel, err,
                    J, JC, INA, RM, WM, SIN, SOUT, WR, NEQ};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Opcode table from the instruction set definition
    function automatic logic [8:0] tableBits(input logic [3:0] op);
        case (op)
            4'd0:    return 9'b000000100;
            4'd1:    return 9'b001001000;
            4'd2:    return 9'b000010000;
            4'd3:    return 9'b000100010;
            4'd4:    return 9'b100000000;
            4'd5:    return 9'b010000000;
            4'd6:    return 9'b000000010;
            4'd7:    return 9'b010000001;
            default: return 9'b000000000;
        endcase
    endfunction

    function automatic cyc_t mkCyc(input logic [2:0] st, input logic memReq, input logic irWe,
                                   input logic pcWe, input logic pcSel, input logic e,
                                   input logic [8:0] ctl, input logic rdy, input logic eqIn,
                                   input logic [3:0] opIn);
        cyc_t c;
        c.exp      = {st, memReq, irWe, pcWe, pcSel, e, ctl};
        c.memReady = rdy;
        c.eqIn     = eqIn;
        c.opIn     = opIn;
        return c;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic addErr();
        for (int i = 0; i < 3; i++)
            trace.push_back(mkCyc(S_ERR, 0, 0, 0, 0, 1, 9'd0, rbit(), rbit(), rop()));
        endsInErr = 1'b1;
    endtask

    // Memory phase: wait cycles with ready low, then one ready cycle, unless the timeout hits first
    task automatic addWaitPhase(input logic [2:0] st, input int waits, input logic [8:0] ctl,
                                output logic timedOut);
        int n;
        timedOut = (waits >= TIMEOUT);
        n = timedOut ? TIMEOUT : waits + 1;
        for (int i = 0; i < n; i++) begin
            logic rdy;
            rdy = !timedOut && (i == n - 1);
            trace.push_back(mkCyc(st, 1, (st == S_FETCH) && rdy, 0, 0, 0, ctl, rdy, rbit(), rop()));
        end
    endtask

    // Reference model: expand one instruction into its expected cycle trace
    task automatic buildTrace(input logic [3:0] op, input int fWait, input int mWait,
                              input logic eqWB);
        logic       to;
        logic [8:0] t;
        trace.delete();
        endsInErr = 1'b0;
        t = tableBits(op);
        addWaitPhase(S_FETCH, fWait, 9'd0, to);
        if (to) begin
            addErr();
            return;
        end
        trace.push_back(mkCyc(S_DECODE, 0, 0, 0, 0, 0, 9'd0, rbit(), rbit(), op));
        if (op >= 4'd8) begin
            addErr();
            return;
        end
        trace.push_back(mkCyc(S_EXEC, 0, 0, 0, 0, 0, t & EXEC_MASK, rbit(), rbit(), rop()));
        if (op == 4'd2 || op == 4'd3) begin
            addWaitPhase(S_MEM, mWait, t & MEM_MASK, to);
            if (to) begin
                addErr();
                return;
            end
        end
        trace.push_back(mkCyc(S_WB, 0, 0, 1, t[8] | (t[7] & (eqWB ^ t[0])), 0, t & WB_MASK,
                              rbit(), eqWB, rop()));
    endtask

    task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got st=%0d req=%b irwe=%b pcwe=%b pcsel=%b err=%b ctl=%b, want st=%0d req=%b irwe=%b pcwe=%b pcsel=%b err=%b ctl=%b",
                     name, act.st, act.memReq, act.irWe, act.pcWe, act.pcSel, act.err, act.ctl,
                     exp.st, exp.memReq, exp.irWe, exp.pcWe, exp.pcSel, exp.err, exp.ctl);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Drive the first 'limit' cycles of the current trace and compare each cycle
    task automatic applyStimulus(input string tag, input int limit, output int pcWeAt,
                                 output logic pcSelSeen, output int wrCount);
        pcWeAt    = 0;
        pcSelSeen = 1'b0;
        wrCount   = 0;
        for (int k = 0; k < trace.size() && k < limit; k++) begin
            mem_ready = trace[k].memReady;
            eq        = trace[k].eqIn;
            opcode    = trace[k].opIn;
            @(negedge clk);
            stateLog.push_back(state);
            checkOutput($sformatf("%s cyc%0d", tag, k), w_act, trace[k].exp);
            if (pc_we) begin
                if (pcWeAt == 0) pcWeAt = k + 1;
                pcSelSeen = pc_sel;
            end
            if (WR) wrCount++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset(input string tag);
        rst       = 1'b1;
        mem_ready = 1'b0;
        eq        = rbit();
        opcode    = rop();
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput({tag, " in reset"}, w_act, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        stateLog.push_back(state);
        checkOutput({tag, " boot"}, w_act, '0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t       vecs[$];
        logic [2:0] expSeq[14];
        int         pcWeAt, wrCount;
        logic       pcSelSeen;

        vecs = '{
            '{4'd0, 0, 0, 1'b0, 4,  1'b0, 0},
            '{4'd3, 0, 0, 1'b0, 5,  1'b0, 1},
            '{4'd4, 0, 0, 1'b0, 4,  1'b1, 0},
            '{4'd5, 0, 0, 1'b1, 4,  1'b1, 0},
            '{4'd5, 0, 0, 1'b0, 4,  1'b0, 0},
            '{4'd7, 0, 0, 1'b0, 4,  1'b1, 0},
            '{4'd7, 0, 0, 1'b1, 4,  1'b0, 0},
            '{4'd2, 0, 3, 1'b1, 8,  1'b0, 0},
            '{4'd1, 2, 0, 1'b1, 6,  1'b0, 0},
            '{4'd6, 1, 0, 1'b1, 5,  1'b0, 1},
            '{4'd3, 3, 3, 1'b0, 11, 1'b0, 1},
            '{4'd10, 0, 0, 1'b0, 0, 1'b0, 0},
            '{4'd4, 4, 0, 1'b1, 0,  1'b0, 0},
            '{4'd2, 0, 4, 1'b0, 0,  1'b0, 0}
        };
        expSeq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                   3'd1, 3'd2, 3'd3, 3'd5};

        rst = 1'b1;
        opcode = 4'd0;
        eq = 1'b0;
        mem_ready = 1'b0;
        stateLog.delete();
        doReset("init");

        // Directed table
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            buildTrace(vecs[i].op, vecs[i].fWait, vecs[i].mWait, vecs[i].eqWB);
            applyStimulus(tag, trace.size(), pcWeAt, pcSelSeen, wrCount);
            checkInt({tag, " pc_we cycle"}, pcWeAt, vecs[i].expPcWeAt);
            checkInt({tag, " pc_sel"}, int'(pcSelSeen), int'(vecs[i].expPcSel));
            checkInt({tag, " WR pulses"}, wrCount, vecs[i].expWr);
            if (i == 2) begin
                checkInt("R/MR/J state count", stateLog.size(), 14);
                for (int s = 0; s < 14 && s < stateLog.size(); s++)
                    checkInt($sformatf("R/MR/J state[%0d]", s), int'(stateLog[s]), int'(expSeq[s]));
            end
            if (endsInErr) doReset({tag, " recover"});
        end

        // Reset in the middle of an MR memory wait, then a normal R
        buildTrace(4'd3, 0, 3, 1'b0);
        applyStimulus("midmem", 5, pcWeAt, pcSelSeen, wrCount);
        checkInt("midmem no pc_we", pcWeAt, 0);
        doReset("midmem");
        buildTrace(4'd0, 0, 0, 1'b0);
        applyStimulus("after midmem", trace.size(), pcWeAt, pcSelSeen, wrCount);
        checkInt("after midmem pc_we cycle", pcWeAt, 4);

        // Randomized instruction stream against the trace model
        for (int n = 0; n < 300; n++) begin
            logic [3:0] op;
            int         fw, mw;
            string      tag;
            tag = $sformatf("rnd%0d", n);
            op  = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            fw  = ($urandom_range(0, 24) == 0) ? TIMEOUT : $urandom_range(0, TIMEOUT - 1);
            mw  = ($urandom_range(0, 24) == 0) ? TIMEOUT + 1 : $urandom_range(0, TIMEOUT - 1);
            buildTrace(op, fw, mw, rbit());
            if ($urandom_range(0, 29) == 0) begin
                applyStimulus(tag, $urandom_range(1, trace.size() - 1), pcWeAt, pcSelSeen, wrCount);
                doReset({tag, " abort"});
            end else begin
                applyStimulus(tag, trace.size(), pcWeAt, pcSelSeen, wrCount);
                if (endsInErr) doReset({tag, " recover"});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
